dmem_access_ctrl: RTL and testbench

//  Sequences and shares the single-port 4K x 32 data RAM between two requesters: port 0 (pipeline MEM stage)
//  and port 1 (debug/program loader). Implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW on a word-only RAM.
//  Sub-word stores use read-modify-write. Sits between the MEM stage/debug unit and ram.

---
 rtl/dmem_access_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Shares a word-only 4K x 32 data RAM between the MEM stage (p0) and debug loader (p1); sub-word stores use read-modify-write.
// Latency accept->rsp: SW/error 1, load 2, SB/SH 3; one op in flight, ready only in IDLE; DMEM_ARB_RR_EN selects round-robin arbitration.
module dmem_access_ctrl #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_req_we,
   input  logic [2:0]        p0_req_funct3,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rsp_rdata,
   output logic              p0_rsp_err,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_req_we,
   input  logic [2:0]        p1_req_funct3,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rsp_rdata,
   output logic              p1_rsp_err,
   output logic [ADDR_W-3:0] data_memory_address,
   output logic [DATA_W-1:0] data_memory_data_in,
   output logic              store,
   output logic              load,
   input  logic [DATA_W-1:0] data_memory_data_out
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR, RESP} state_t;

   state_t              state, state_nxt;
   logic                grant0, grant1, accept, sel;
   logic                req_we, f3_illegal, misaligned, req_err;
   logic [2:0]          req_f3;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;

   logic                owner_q, we_q, err_q;
   logic [2:0]          f3_q;
   logic [1:0]          lo_q;
   logic [ADDR_W-3:0]   waddr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q, merged_q;
   logic [7:0]          rd_byte;
   logic [15:0]         rd_half;
   logic [DATA_W-1:0]   ld_val, merge_val;

`ifdef DMEM_ARB_RR_EN
   logic last_grant;

   // On contention the port that did not win last time gets the slot.
   assign grant0 = p0_req_valid & (~p1_req_valid | last_grant);
   assign grant1 = p1_req_valid & (~p0_req_valid | ~last_grant);

   always_ff @(posedge clk) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= sel;
   end
`else
   assign grant0 = p0_req_valid;
   assign grant1 = p1_req_valid & ~p0_req_valid;
`endif

   assign p0_req_ready = rst_n & (state == IDLE) & grant0;
   assign p1_req_ready = rst_n & (state == IDLE) & grant1;
   assign accept       = p0_req_ready | p1_req_ready;
   assign sel          = p1_req_ready;

   assign req_we    = sel ? p1_req_we     : p0_req_we;
   assign req_f3    = sel ? p1_req_funct3 : p0_req_funct3;
   assign req_addr  = sel ? p1_req_addr   : p0_req_addr;
   assign req_wdata = sel ? p1_req_wdata  : p0_req_wdata;

   assign f3_illegal = (req_f3 == 3'b011) | (req_f3[2:1] == 2'b11);
   assign misaligned = ((req_f3[1:0] == 2'b01) & req_addr[0]) |
                       ((req_f3 == 3'b010) & (req_addr[1:0] != 2'b00));
   assign req_err    = f3_illegal | misaligned;

   always_comb begin
      rd_byte = data_memory_data_out[7:0];
      case (lo_q)
         2'd1:    rd_byte = data_memory_data_out[15:8];
         2'd2:    rd_byte = data_memory_data_out[23:16];
         2'd3:    rd_byte = data_memory_data_out[31:24];
         default: rd_byte = data_memory_data_out[7:0];
      endcase
      rd_half = lo_q[1] ? data_memory_data_out[31:16] : data_memory_data_out[15:0];

      case (f3_q)
         3'b000:  ld_val = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  ld_val = {24'd0, rd_byte};
         3'b001:  ld_val = {{16{rd_half[15]}}, rd_half};
         3'b101:  ld_val = {16'd0, rd_half};
         default: ld_val = data_memory_data_out;
      endcase

      // f3[1:0]==00 is a byte store, otherwise a halfword store.
      merge_val = data_memory_data_out;
      if (f3_q[1:0] == 2'b00) begin
         case (lo_q)
            2'd1:    merge_val[15:8]  = wdata_q[7:0];
            2'd2:    merge_val[23:16] = wdata_q[7:0];
            2'd3:    merge_val[31:24] = wdata_q[7:0];
            default: merge_val[7:0]   = wdata_q[7:0];
         endcase
      end else if (lo_q[1]) begin
         merge_val[31:16] = wdata_q[15:0];
      end else begin
         merge_val[15:0] = wdata_q[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt           = state;
      load                = 1'b0;
      store               = 1'b0;
      data_memory_address = '0;
      data_memory_data_in = '0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (req_err) begin
                     state_nxt = RESP;
                  end else if (req_we && (req_f3 == 3'b010)) begin
                     store               = 1'b1;
                     data_memory_address = req_addr[ADDR_W-1:2];
                     data_memory_data_in = req_wdata;
                     state_nxt           = RESP;
                  end else begin
                     load                = 1'b1;
                     data_memory_address = req_addr[ADDR_W-1:2];
                     state_nxt           = RD_WAIT;
                  end
               end
            end
            RD_WAIT: state_nxt = we_q ? RMW_WR : RESP;
            RMW_WR: begin
               store               = 1'b1;
               data_memory_address = waddr_q;
               data_memory_data_in = merged_q;
               state_nxt           = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         f3_q     <= '0;
         lo_q     <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         merged_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner_q <= sel;
                  we_q    <= req_we;
                  err_q   <= req_err;
                  f3_q    <= req_f3;
                  lo_q    <= req_addr[1:0];
                  waddr_q <= req_addr[ADDR_W-1:2];
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
               end
            end
            RD_WAIT: begin
               if (we_q)
                  merged_q <= merge_val;
               else
                  rdata_q <= ld_val;
            end
            default: ;
         endcase
      end
   end

   // Responses appear only on the owning port; everything else reads as zero.
   assign p0_rsp_valid = rst_n & (state == RESP) & ~owner_q;
   assign p1_rsp_valid = rst_n & (state == RESP) & owner_q;
   assign p0_rsp_err   = p0_rsp_valid & err_q;
   assign p1_rsp_err   = p1_rsp_valid & err_q;
   assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : '0;
   assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: RAM model, behavioural response/arbitration model, per-cycle compare and directed vectors.
module tb_dmem_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_err;
   logic [2:0]  p0_req_funct3;
   logic [13:0] p0_req_addr;
   logic [31:0] p0_req_wdata, p0_rsp_rdata;
   logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_err;
   logic [2:0]  p1_req_funct3;
   logic [13:0] p1_req_addr;
   logic [31:0] p1_req_wdata, p1_rsp_rdata;
   logic [11:0] data_memory_address;
   logic [31:0] data_memory_data_in, data_memory_data_out;
   logic        store, load;

   dmem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_funct3(p0_req_funct3), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_funct3(p1_req_funct3), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
      .data_memory_address(data_memory_address), .data_memory_data_in(data_memory_data_in),
      .store(store), .load(load), .data_memory_data_out(data_memory_data_out)
   );

   bit [31:0] ram [4096];
   always @(posedge clk) begin
      if (store) ram[data_memory_address] <= data_memory_data_in;
      if (load)  data_memory_data_out <= ram[data_memory_address];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Behavioural model state
   bit [31:0]   shadow [4096];
   bit          pend = 0, pend_port, pend_err, pend_wr;
   int          pend_due, pend_acc;
   bit [31:0]   pend_rdata, pend_wword;
   bit [11:0]   pend_waddr;
   bit          model_last = 1;
   int          cyc = 0;
   int          n_load = 0, n_store = 0, n_rsp = 0;
   logic [11:0] st_addr;
   logic [31:0] st_data;
   bit          lat_seen;
   int          last_lat;
   logic [31:0] last_rdata;
   logic        last_err;
   int          grant_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_accept(input bit port, input logic we, input logic [2:0] f3,
                               input logic [13:0] a, input logic [31:0] wd);
      bit [31:0] w, b, h;
      int        sh, shh;
      w   = shadow[a[13:2]];
      sh  = 8 * a[1:0];
      shh = a[1] ? 16 : 0;
      b   = (w >> sh) & 32'hFF;
      h   = (w >> shh) & 32'hFFFF;
      pend = 1; pend_port = port; pend_acc = cyc; pend_waddr = a[13:2];
      pend_err = 0; pend_wr = 0; pend_rdata = 0; pend_wword = 0;
      if (f3 == 3 || f3 == 6 || f3 == 7 || ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 0)) begin
         pend_err = 1; pend_due = cyc + 1;
      end else if (!we) begin
         pend_due = cyc + 2;
         case (f3)
            3'd0:    pend_rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    pend_rdata = b;
            3'd1:    pend_rdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    pend_rdata = h;
            default: pend_rdata = w;
         endcase
      end else if (f3 == 2) begin
         pend_due = cyc + 1; pend_wr = 1; pend_wword = wd;
      end else if (f3 == 0 || f3 == 4) begin
         pend_due = cyc + 3; pend_wr = 1;
         pend_wword = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else begin
         pend_due = cyc + 3; pend_wr = 1;
         pend_wword = (w & ~(32'hFFFF << shh)) | ((wd & 32'hFFFF) << shh);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      logic [71:0] a_v, e_v;
      bit          win;
      if (load)  n_load++;
      if (store) begin n_store++; st_addr = data_memory_address; st_data = data_memory_data_in; end
      chk("strobe_excl", {71'd0, load & store}, 72'd0);
      if (!rst_n) begin
         pend = 0; model_last = 1;
      end else begin
         if (p0_rsp_valid || p1_rsp_valid) n_rsp++;
         a_v = {4'd0, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata};
         e_v = '0;
         if (pend && cyc == pend_due) begin
            if (pend_port) e_v[33:0]  = {1'b1, pend_err, pend_rdata};
            else           e_v[67:34] = {1'b1, pend_err, pend_rdata};
         end
         chk("rsp", a_v, e_v);
         if (pend && (p0_rsp_valid || p1_rsp_valid) && !lat_seen) begin
            lat_seen   = 1;
            last_lat   = cyc - pend_acc;
            last_rdata = pend_port ? p1_rsp_rdata : p0_rsp_rdata;
            last_err   = pend_port ? p1_rsp_err : p0_rsp_err;
         end
         if (pend && cyc >= pend_due) begin
            if (pend_wr && !pend_err) shadow[pend_waddr] = pend_wword;
            pend = 0;
         end
         if (pend) chk("ready_busy", {70'd0, p1_req_ready, p0_req_ready}, 72'd0);
         else if (p0_req_ready || p1_req_ready) begin
`ifdef DMEM_ARB_RR_EN
            if (p0_req_valid && p1_req_valid) win = ~model_last;
`else
            if (p0_req_valid && p1_req_valid) win = 0;
`endif
            else win = p1_req_valid;
            chk("arb_ready", {70'd0, p1_req_ready, p0_req_ready}, win ? 72'd2 : 72'd1);
            grant_q.push_back(int'(p1_req_ready));
            model_last = win;
            lat_seen   = 0;
            if (win) model_accept(1, p1_req_we, p1_req_funct3, p1_req_addr, p1_req_wdata);
            else     model_accept(0, p0_req_we, p0_req_funct3, p0_req_addr, p0_req_wdata);
         end
      end
   end

   task automatic issue(input bit port, input logic we, input logic [2:0] f3,
                        input logic [13:0] a, input logic [31:0] wd);
      bit done = 0;
      @(posedge clk); #1;
      if (port) begin
         p1_req_valid = 1; p1_req_we = we; p1_req_funct3 = f3; p1_req_addr = a; p1_req_wdata = wd;
      end else begin
         p0_req_valid = 1; p0_req_we = we; p0_req_funct3 = f3; p0_req_addr = a; p0_req_wdata = wd;
      end
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         done = port ? p1_req_ready : p0_req_ready;
      end
      chk("accept", {71'd0, done}, 72'd1);
      @(posedge clk); #1;
      p0_req_valid = 0; p1_req_valid = 0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 20 && pend; k++) @(posedge clk);
      chk("done", {71'd0, pend}, 72'd0);
   endtask

   int ds, dl;
   task automatic run(input bit port, input logic we, input logic [2:0] f3,
                      input logic [13:0] a, input logic [31:0] wd);
      int s0, l0;
      s0 = n_store; l0 = n_load;
      last_lat = -1; last_rdata = 32'hDEAD_BEEF; last_err = 1'bx;
      issue(port, we, f3, a, wd);
      wait_done();
      ds = n_store - s0; dl = n_load - l0;
   endtask

   initial begin
      int g0, s0, r0, k;
      rst_n = 0;
      p0_req_valid = 0; p0_req_we = 0; p0_req_funct3 = 0; p0_req_addr = 0; p0_req_wdata = 0;
      p1_req_valid = 0; p1_req_we = 0; p1_req_funct3 = 0; p1_req_addr = 0; p1_req_wdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ram_if", {26'd0, load, store, data_memory_address, data_memory_data_in}, 72'd0);
      chk("reset_rsp", {4'd0, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata}, 72'd0);
      @(posedge clk); #1 rst_n = 1;

      // SW then LW at 0x1EC
      run(0, 1, 3'b010, 14'h1EC, 32'h1234_CDEF);
      chk("t1_sw_lat", last_lat, 1);
      chk("t1_sw_addr", st_addr, 123);
      chk("t1_sw_data", st_data, 32'h1234_CDEF);
      chk("t1_sw_strobes", {ds[15:0], dl[15:0]}, {16'd1, 16'd0});
      run(0, 0, 3'b010, 14'h1EC, 0);
      chk("t1_lw_lat", last_lat, 2);
      chk("t1_lw_rdata", {last_err, last_rdata}, {1'b0, 32'h1234_CDEF});
      chk("t1_lw_strobes", {ds[15:0], dl[15:0]}, {16'd0, 16'd1});

      // Sub-word stores and loads on the top word
      run(1, 1, 3'b010, 14'h3FFC, 32'h8899_AABB);
      chk("t2_p1_sw_lat", last_lat, 1);
      run(0, 1, 3'b000, 14'h3FFD, 32'h0000_0011);
      chk("t2_sb_lat", last_lat, 3);
      chk("t2_sb_word", {st_addr, st_data}, {12'hFFF, 32'h8899_11BB});
      chk("t2_sb_strobes", {ds[15:0], dl[15:0]}, {16'd1, 16'd1});
      run(0, 0, 3'b000, 14'h3FFD, 0);
      chk("t2_lb", last_rdata, 32'h0000_0011);
      run(0, 0, 3'b100, 14'h3FFE, 0);
      chk("t2_lbu", last_rdata, 32'h0000_0099);
      run(0, 0, 3'b000, 14'h3FFC, 0);
      chk("t2_lb_neg", last_rdata, 32'hFFFF_FFBB);

      run(0, 0, 3'b001, 14'h3FFE, 0);
      chk("t3_lh", last_rdata, 32'hFFFF_8899);
      run(0, 0, 3'b101, 14'h3FFE, 0);
      chk("t3_lhu", last_rdata, 32'h0000_8899);
      run(0, 0, 3'b001, 14'h0001, 0);
      chk("t3_lh_mis", {last_lat[7:0], last_err, last_rdata}, {8'd1, 1'b1, 32'd0});
      chk("t3_mis_strobes", {ds[15:0], dl[15:0]}, 32'd0);
      run(0, 1, 3'b001, 14'h3FFC, 32'hABCD_1234);
      chk("t3_sh_word", {last_lat[7:0], st_data}, {8'd3, 32'h8899_1234});
      run(0, 1, 3'b010, 14'h3FFE, 32'h5555_5555);
      chk("t3_sw_mis", {last_lat[7:0], last_err, ds[15:0]}, {8'd1, 1'b1, 16'd0});

      // Contention: both ports valid until six accepts
      g0 = grant_q.size();
      @(posedge clk); #1;
      p0_req_we = 0; p0_req_funct3 = 3'b010; p0_req_addr = 14'h1EC;  p0_req_valid = 1;
      p1_req_we = 0; p1_req_funct3 = 3'b010; p1_req_addr = 14'h3FFC; p1_req_valid = 1;
      k = 0;
      while (grant_q.size() - g0 < 6 && k < 200) begin @(posedge clk); k++; end
      #1; p0_req_valid = 0; p1_req_valid = 0;
      chk("t4_accepts", grant_q.size() - g0, 6);
      wait_done();
      for (int i = 0; i < 6 && g0 + i < grant_q.size(); i++) begin
`ifdef DMEM_ARB_RR_EN
         chk($sformatf("t4_grant%0d", i), grant_q[g0 + i], (i % 2 == 0) ? 1 : 0);
`else
         chk($sformatf("t4_grant%0d", i), grant_q[g0 + i], 0);
`endif
      end

      // Reset during the read half of an SB
      run(0, 1, 3'b010, 14'h0010, 32'hCAFE_F00D);
      s0 = n_store; r0 = n_rsp;
      issue(0, 1, 3'b000, 14'h0010, 32'h0000_00AA);
      rst_n = 0;
      @(posedge clk); #1 rst_n = 1;
      repeat (5) @(posedge clk);
      chk("t5_no_store", n_store - s0, 0);
      chk("t5_no_rsp", n_rsp - r0, 0);
      chk("t5_ram_word", ram[4], 32'hCAFE_F00D);
      run(0, 0, 3'b010, 14'h0010, 0);
      chk("t5_lw_after", last_rdata, 32'hCAFE_F00D);

      // Illegal funct3 from the debug port
      run(1, 0, 3'b111, 14'h0020, 0);
      chk("t6_err", {last_lat[7:0], last_err, last_rdata}, {8'd1, 1'b1, 32'd0});
      chk("t6_strobes", {ds[15:0], dl[15:0]}, 32'd0);

      chk("ram_fff", ram[12'hFFF], 32'h8899_1234);
      chk("ram_07b", ram[12'h07B], 32'h1234_CDEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
